priority_arbiter_rr: RTL and testbench
======================================

Name: priority_arbiter_rr

Overview:
Parametrised, registered successor to the 8-to-3 priority encoder. It takes N request lines and selects one winner, using either fixed MSB-first priority or round-robin priority. The winner's binary index and one-hot grant are held on a valid/ack handshake until the consumer accepts them. It sits between request sources and a shared resource, for example a shared bus or a display/memory port.

Parameters:
N, 8, number of request lines; must be ≥2.
IDX_W, 3, width of the index output; must equal ceil(log2(N)).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
req  input  N  request vector; bit i is requester i.
rr_mode  input  1  0 = fixed priority (highest index wins); 1 = round-robin. Sampled only in IDLE.
ack  input  1  consumer accepts the current grant.
valid  output  1  a grant is presented.
index  output  IDX_W  binary index of the granted requester.
grant  output  N  one-hot grant; equals 1<<index when valid=1, else 0.
busy  output  1  1 while in GRANT state (equals valid).

Behaviour:
- Reset, sampled on the rising edge of clk:
  - valid=0, index=0, grant=0, busy=0.
  - Round-robin pointer last=0.
  - FSM goes to IDLE.
  - Reset overrides every other input in the same cycle, including reset asserted mid-grant: the grant is dropped and no ack is needed.
- FSM states: IDLE and GRANT.
- IDLE:
  - If req==0: stay in IDLE; outputs stay 0.
  - If req!=0: compute the winner from the current req and rr_mode. At the next edge, register index and grant, set valid=1, load last=winner, go to GRANT.
  - Latency from req to valid is exactly 1 cycle.
- GRANT:
  - index and grant are frozen while ack=0, regardless of req changes, including the winner dropping its request.
  - ack=1: at the next edge, valid=0, grant=0, go to IDLE. index keeps its last value.
  - There is always one IDLE cycle between grants, so the maximum rate is one grant per 2 cycles.
  - ack while in IDLE is ignored.
- Fixed priority (rr_mode=0):
  - The winner is the highest set bit of req, matching the truth table of the 8-to-3 encoder for N=8.
- Round-robin (rr_mode=1):
  - Search order is last-1, last-2, …, 0, N-1, …, last, all modulo N. The first set bit wins.
  - With last=0 after reset, the order is N-1…0, identical to fixed priority.
  - The requester granted most recently has the lowest priority.
- last updates on every grant issue in both modes. Switching mode never corrupts last.
- No request (req==0) never produces valid=1. There is no X/default output path.
- index width: the winner index is computed in IDX_W bits; no truncation occurs for N ≤ 2^IDX_W.

Optional Feature:
PRIORITY_ARBITER_COUNT_EN.
- Defined: adds output grant_count[15:0].
  - Reset value 0.
  - Increments by 1 at each edge where state=GRANT and ack=1.
  - Saturates at 16'hFFFF and does not wrap.
- Undefined: the port and the counter logic are absent. All other behaviour is identical.

Test Plan:
1. Reset then idle: reset=1 for 2 cycles, then req=0 for 5 cycles -> valid=0, grant=0, index=0 throughout.
2. Fixed priority, N=8: rr_mode=0, req=8'b0010_0100 -> one cycle later valid=1, index=5, grant=8'b0010_0000. Hold ack=0 for 3 cycles while req changes to 8'b1000_0000 -> outputs unchanged. Then ack=1 -> valid=0 on the next cycle.
3. Round-robin rotation: rr_mode=1, req held at 8'b0010_0100, ack asserted on each grant -> grant sequence index 5, 2, 5, 2, with exactly one valid=0 cycle between grants.
4. Round-robin wrap: rr_mode=1, the last grant was index 0, req=8'b1000_0001 -> next index=7. Following grant with the same req -> index=0.
5. Reset mid-grant: valid=1, index=3, ack=0, reset=1 for one cycle -> next cycle valid=0, grant=0. Then req=8'b0000_0011 with rr_mode=1 -> index=1, confirming last was reset to 0.
6. PRIORITY_ARBITER_COUNT_EN defined: 4 completed handshakes -> grant_count=4. Force 65536 handshakes -> grant_count holds 16'hFFFF.

Source files
------------

// File: rtl/priority_arbiter_rr.sv
// priority_arbiter_rr: picks one of N requesters (fixed MSB-first or round-robin) and holds the grant
// Latency: 1 cycle from req to valid; at most one grant per 2 cycles (always one IDLE cycle between grants)
// Backpressure: index/grant stay frozen while ack=0; req changes during a grant are ignored
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   req[N-1:0]          - request vector, bit i = requester i
//   rr_mode             - 0 fixed priority (highest index wins), 1 round-robin; sampled in IDLE only
//   ack                 - consumer accepts the presented grant
//   valid/busy          - grant presented (busy mirrors the GRANT state)
//   index[IDX_W-1:0]    - binary index of the winner (holds its last value after ack)
//   grant[N-1:0]        - one-hot grant, zero when valid=0
//   grant_count[15:0]   - saturating count of completed handshakes, only with PRIORITY_ARBITER_COUNT_EN
module priority_arbiter_rr #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             rr_mode,
  input  logic             ack,
  output logic             valid,
  output logic [IDX_W-1:0] index,
  output logic [N-1:0]     grant,
  output logic             busy
`ifdef PRIORITY_ARBITER_COUNT_EN
  ,
  output logic [15:0]      grant_count
`endif
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  state_e           state_q;
  logic             valid_q;
  logic [IDX_W-1:0] index_q;
  logic [N-1:0]     grant_q;
  logic [IDX_W-1:0] last_q;

  logic [IDX_W-1:0] fix_idx_d, rr_idx_d, win_idx_d;
  logic [N-1:0]     fix_oh_d, rr_oh_d, win_oh_d;
  int               rank, best_rank;

  // Winner selection. Fixed priority: ascending scan, the last set bit seen
  // is the highest index. Round-robin: each requester gets a rank equal to
  // its distance below last (last-1 -> 0, ..., last -> N-1); lowest rank wins,
  // so the most recently granted requester is always served last.
  always_comb begin
    fix_idx_d = '0;
    fix_oh_d  = '0;
    rr_idx_d  = '0;
    rr_oh_d   = '0;
    rank      = 0;
    best_rank = N;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        fix_idx_d   = IDX_W'(i);
        fix_oh_d    = '0;
        fix_oh_d[i] = 1'b1;
        rank = (int'(last_q) - i - 1 + 2 * N) % N;
        if (rank < best_rank) begin
          best_rank  = rank;
          rr_idx_d   = IDX_W'(i);
          rr_oh_d    = '0;
          rr_oh_d[i] = 1'b1;
        end
      end
    end
    win_idx_d = rr_mode ? rr_idx_d : fix_idx_d;
    win_oh_d  = rr_mode ? rr_oh_d  : fix_oh_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      index_q <= '0;
      grant_q <= '0;
      last_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            index_q <= win_idx_d;
            grant_q <= win_oh_d;
            valid_q <= 1'b1;
            last_q  <= win_idx_d;  // updated in both modes so switching mode is seamless
            state_q <= GRANT;
          end
        end
        GRANT: begin
          // index_q deliberately keeps the last winner after the handshake
          if (ack) begin
            valid_q <= 1'b0;
            grant_q <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef PRIORITY_ARBITER_COUNT_EN
  logic [15:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (state_q == GRANT && ack && count_q != 16'hFFFF) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign grant_count = count_q;
`endif

  assign valid = valid_q;
  assign index = index_q;
  assign grant = grant_q;
  assign busy  = (state_q == GRANT);

endmodule

// File: tb/tb_priority_arbiter_rr.sv
// tb_priority_arbiter_rr: directed table-driven bench for priority_arbiter_rr (N=8)
// Latency: each table row is applied, one clock edge elapses, outputs are compared 1 time unit later
// Backpressure: ack is driven explicitly per row to exercise hold and release
module tb_priority_arbiter_rr;

  localparam int N     = 8;
  localparam int IDX_W = 3;

  logic             clk;
  logic             reset;
  logic [N-1:0]     req;
  logic             rr_mode;
  logic             ack;
  logic             valid;
  logic [IDX_W-1:0] index;
  logic [N-1:0]     grant;
  logic             busy;
`ifdef PRIORITY_ARBITER_COUNT_EN
  logic [15:0]      grant_count;
`endif

  priority_arbiter_rr #(.N(N), .IDX_W(IDX_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .rr_mode (rr_mode),
    .ack     (ack),
    .valid   (valid),
    .index   (index),
    .grant   (grant),
    .busy    (busy)
`ifdef PRIORITY_ARBITER_COUNT_EN
    ,
    .grant_count (grant_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         rst;
    logic [N-1:0] req;
    logic         rr;
    logic         ack;
    logic         e_valid;
    logic [2:0]   e_index;
    logic [N-1:0] e_grant;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic add(input string name, input logic rst, input logic [N-1:0] r, input logic rr,
                     input logic a, input logic ev, input logic [2:0] ei, input logic [N-1:0] eg);
    vec_t v;
    v.name = name; v.rst = rst; v.req = r; v.rr = rr; v.ack = a;
    v.e_valid = ev; v.e_index = ei; v.e_grant = eg;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string name, input logic ev, input logic [2:0] ei,
                               input logic [N-1:0] eg);
    check({name, ".valid"}, 32'(valid), 32'(ev));
    check({name, ".index"}, 32'(index), 32'(ei));
    check({name, ".grant"}, 32'(grant), 32'(eg));
    check({name, ".busy"},  32'(busy),  32'(ev));
  endtask

  initial begin
    reset = 1'b1; req = '0; rr_mode = 1'b0; ack = 1'b0;

    // reset, then idle with no requests
    add("rst0",  1, 8'h00, 0, 0, 0, 0, 8'h00);
    add("rst1",  1, 8'h00, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) add("idle", 0, 8'h00, 0, 0, 0, 0, 8'h00);
    // fixed priority, hold under changing req, release
    add("fix_gnt",   0, 8'h24, 0, 0, 1, 5, 8'h20);
    add("fix_hold1", 0, 8'h80, 0, 0, 1, 5, 8'h20);
    add("fix_hold2", 0, 8'h80, 0, 0, 1, 5, 8'h20);
    add("fix_hold3", 0, 8'h80, 0, 0, 1, 5, 8'h20);
    add("fix_ack",   0, 8'h80, 0, 1, 0, 5, 8'h00);
    add("idle_ack",  0, 8'h00, 0, 1, 0, 5, 8'h00);
    // reset wins over a pending request; round-robin rotation 5,2,5,2
    add("rst_ovr",   1, 8'h24, 1, 0, 0, 0, 8'h00);
    add("rr_g5a",    0, 8'h24, 1, 0, 1, 5, 8'h20);
    add("rr_a5a",    0, 8'h24, 1, 1, 0, 5, 8'h00);
    add("rr_g2a",    0, 8'h24, 1, 0, 1, 2, 8'h04);
    add("rr_a2a",    0, 8'h24, 1, 1, 0, 2, 8'h00);
    add("rr_g5b",    0, 8'h24, 1, 0, 1, 5, 8'h20);
    add("rr_a5b",    0, 8'h24, 1, 1, 0, 5, 8'h00);
    add("rr_g2b",    0, 8'h24, 1, 0, 1, 2, 8'h04);
    add("rr_a2b",    0, 8'h24, 1, 1, 0, 2, 8'h00);
    // wrap: last=2, only req0 -> 0; then 0x81 -> 7, then 0
    add("wrap_g0",   0, 8'h01, 1, 0, 1, 0, 8'h01);
    add("wrap_a0",   0, 8'h01, 1, 1, 0, 0, 8'h00);
    add("wrap_g7",   0, 8'h81, 1, 0, 1, 7, 8'h80);
    add("wrap_a7",   0, 8'h81, 1, 1, 0, 7, 8'h00);
    add("wrap_g0b",  0, 8'h81, 1, 0, 1, 0, 8'h01);
    add("wrap_a0b",  0, 8'h81, 1, 1, 0, 0, 8'h00);
    // fixed-mode grant still updates last: fixed 7, then round-robin picks 0
    add("mode_fix7", 0, 8'h81, 0, 0, 1, 7, 8'h80);
    add("mode_a7",   0, 8'h81, 0, 1, 0, 7, 8'h00);
    add("mode_rr0",  0, 8'h81, 1, 0, 1, 0, 8'h01);
    add("mode_a0",   0, 8'h00, 1, 1, 0, 0, 8'h00);

    foreach (vecs[k]) begin
      reset = vecs[k].rst; req = vecs[k].req; rr_mode = vecs[k].rr; ack = vecs[k].ack;
      tick();
      check_outputs(vecs[k].name, vecs[k].e_valid, vecs[k].e_index, vecs[k].e_grant);
    end

    // reset in the middle of a grant, then last must be back at 0
    reset = 0; rr_mode = 0; ack = 0; req = 8'h08;
    tick();
    check_outputs("mid_gnt3", 1, 3, 8'h08);
    reset = 1; req = 8'h00;
    tick();
    check_outputs("mid_rst", 0, 0, 8'h00);
    reset = 0; rr_mode = 1; req = 8'h03;
    tick();
    check_outputs("post_rst_g1", 1, 1, 8'h02);
    ack = 1;
    tick();
    check_outputs("post_rst_a1", 0, 1, 8'h00);
    ack = 0;  // last=1 now: requester 0 is next in line ahead of 1
    tick();
    check_outputs("post_rst_g0", 1, 0, 8'h01);
    ack = 1; req = 8'h00;
    tick();
    check_outputs("post_rst_a0", 0, 0, 8'h00);

`ifdef PRIORITY_ARBITER_COUNT_EN
    reset = 1; ack = 0; req = 8'h00;
    tick();
    check("cnt_reset", 32'(grant_count), 32'd0);
    reset = 0; req = 8'h10; ack = 1;
    // ack stays high: each handshake takes one IDLE and one GRANT cycle
    for (int i = 0; i < 8; i++) tick();
    #0;
    check("cnt_4", 32'(grant_count), 32'd4);
    for (int i = 0; i < 2 * 65536; i++) tick();
    check("cnt_sat", 32'(grant_count), 32'hFFFF);
    for (int i = 0; i < 4; i++) tick();
    check("cnt_hold", 32'(grant_count), 32'hFFFF);
    req = 8'h00; ack = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
